// File: rtl/fir_pkg.sv
// Shared types and default sizes for the FIR sequencer/MAC slice.
package fir_pkg;

  localparam int N_TAPS = 16;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 21;
  localparam int TAP_W  = $clog2(N_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  typedef logic [TAP_W-1:0] tap_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    MAC,
    SAVE,
    DONE
  } state_t;

endpackage

// File: rtl/fir_mac_seq_if.sv
// Sample handshake, coefficient ROM bus and accumulator strobes of the FIR MAC sequencer.
interface fir_mac_seq_if;
  import fir_pkg::*;

  logic                     probka_valid;
  logic signed [DATA_W-1:0] probka_in;
  logic                     probka_ready;
  tap_idx_t                 coef_addr;
  logic                     coef_rd_en;
  logic signed [COEF_W-1:0] coef_data;
  logic signed [ACC_W-1:0]  Acc_out;
  logic signed [ACC_W-1:0]  suma_wynik;
  logic                     FSM_reset_Acc;
  logic                     FSM_Acc_en;
  logic                     FSM_Acc_zapis;
  logic                     busy;
  logic                     wynik_valid;

  modport slave (
    input  probka_valid, probka_in, coef_data, Acc_out,
    output probka_ready, coef_addr, coef_rd_en, suma_wynik,
           FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis, busy, wynik_valid
  );

  modport master (
    output probka_valid, probka_in, coef_data, Acc_out,
    input  probka_ready, coef_addr, coef_rd_en, suma_wynik,
           FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis, busy, wynik_valid
  );

endinterface

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write per accepted sample, combinational tap read.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic                     clk_b,
  input  logic                     rst_n,
  input  logic                     i_wrEn,
  input  logic signed [DATA_W-1:0] i_din,
  input  tap_idx_t                 i_rdIdx,
  output logic signed [DATA_W-1:0] o_dout,
  output tap_idx_t                 o_newest
);

  logic signed [DATA_W-1:0] r_buf [N_TAPS];
  tap_idx_t                 r_wrPtr;
  tap_idx_t                 r_newest;

  // Entries are zeroed on reset so taps older than the first sample read as zero.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_buf[i] <= '0;
      end
      r_wrPtr  <= '0;
      r_newest <= '0;
    end else if (i_wrEn) begin
      r_buf[r_wrPtr] <= i_din;
      r_newest       <= r_wrPtr;
      r_wrPtr        <= r_wrPtr + tap_idx_t'(1);
    end
  end

  assign o_dout   = r_buf[i_rdIdx];
  assign o_newest = r_newest;

endmodule

// File: rtl/fir_mac_seq.sv
// FIR sequencer: stores a sample, walks all taps through the MAC and strobes the accumulator.
module fir_mac_seq
  import fir_pkg::*;
(
  input  logic          clk_b,
  input  logic          rst_n,
  fir_mac_seq_if.slave  bus
);

  localparam tap_idx_t LAST_TAP = tap_idx_t'(N_TAPS - 1);

  state_t                   r_state;
  state_t                   w_nextState;
  tap_idx_t                 r_k;
  tap_idx_t                 w_nextK;
  tap_idx_t                 w_kInc;
  tap_idx_t                 w_newest;
  tap_idx_t                 w_rdIdx;
  logic                     w_wrEn;
  logic signed [DATA_W-1:0] w_sample;
  logic signed [PROD_W-1:0] w_prod;
  logic        [ACC_W-1:0]  w_prodExt;

  assign w_wrEn    = (r_state == IDLE) && bus.probka_valid;
  assign w_rdIdx   = w_newest - r_k;
  assign w_kInc    = r_k + tap_idx_t'(1);
  assign w_prod    = w_sample * bus.coef_data;
  assign w_prodExt = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  fir_delay_line u_delayLine (
    .clk_b    (clk_b),
    .rst_n    (rst_n),
    .i_wrEn   (w_wrEn),
    .i_din    (bus.probka_in),
    .i_rdIdx  (w_rdIdx),
    .o_dout   (w_sample),
    .o_newest (w_newest)
  );

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_nextState;
      r_k     <= w_nextK;
    end
  end

  // ROM address runs one tap ahead of k because coef_data arrives a cycle after the read.
  always_comb begin
    w_nextState       = r_state;
    w_nextK           = r_k;
    bus.probka_ready  = 1'b0;
    bus.busy          = 1'b1;
    bus.coef_rd_en    = 1'b0;
    bus.coef_addr     = '0;
    bus.suma_wynik    = '0;
    bus.FSM_reset_Acc = 1'b0;
    bus.FSM_Acc_en    = 1'b0;
    bus.FSM_Acc_zapis = 1'b0;
    bus.wynik_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        bus.probka_ready = 1'b1;
        bus.busy         = 1'b0;
        if (bus.probka_valid) begin
          w_nextState = CLR;
        end
      end
      CLR: begin
        bus.FSM_reset_Acc = 1'b1;
        bus.coef_rd_en    = 1'b1;
        w_nextK           = '0;
        w_nextState       = MAC;
      end
      MAC: begin
        bus.FSM_Acc_en = 1'b1;
        bus.suma_wynik = bus.Acc_out + w_prodExt;
        if (r_k != LAST_TAP) begin
          bus.coef_rd_en = 1'b1;
          bus.coef_addr  = w_kInc;
          w_nextK        = w_kInc;
        end else begin
          w_nextState = SAVE;
        end
      end
      SAVE: begin
        bus.FSM_Acc_zapis = 1'b1;
        w_nextState       = DONE;
      end
      DONE: begin
        bus.wynik_valid = 1'b1;
        w_nextState     = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq with a 1-cycle coefficient ROM and downstream accumulator model.
module tb_fir_mac_seq;
  import fir_pkg::*;

  logic clk_b = 1'b0;
  logic rst_n = 1'b0;

  fir_mac_seq_if bus ();

  fir_mac_seq dut (
    .clk_b (clk_b),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_b = ~clk_b;

  int errorCount = 0;
  int checkCount = 0;

  logic signed [COEF_W-1:0] rom [N_TAPS];
  logic signed [ACC_W-1:0]  accReg;
  logic        [15:0]       resultReg;
  int history[$];

  int lastLatency;
  int lastResult;
  int lastSuma;

  always_ff @(posedge clk_b) begin
    if (bus.coef_rd_en) bus.coef_data <= rom[bus.coef_addr];
  end

  // Accumulator and result register sitting downstream of the sequencer.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      accReg    <= '0;
      resultReg <= '0;
    end else if (bus.FSM_reset_Acc) begin
      accReg    <= '0;
      resultReg <= '0;
    end else begin
      if (bus.FSM_Acc_en)    accReg    <= bus.suma_wynik;
      if (bus.FSM_Acc_zapis) resultReg <= accReg[15:0];
    end
  end

  assign bus.Acc_out = accReg;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int golden();
    int s = 0;
    for (int k = 0; k < N_TAPS; k++) begin
      int idx = history.size() - 1 - k;
      if (idx >= 0) s += history[idx] * int'(rom[k]);
    end
    return s & 'hFFFF;
  endfunction

  task automatic setRom(input int mode);
    for (int k = 0; k < N_TAPS; k++) begin
      case (mode)
        0: rom[k] = COEF_W'(k + 1);
        1: rom[k] = -8'sd128;
        2: rom[k] = (k == 0) ? 8'sd5 : 8'sd0;
        3: rom[k] = COEF_W'(k - 8);
        4: rom[k] = 8'sd3;
        default: rom[k] = 8'sd2;
      endcase
    end
  endtask

  // Waits for IDLE, hands in one sample and follows the computation to wynik_valid.
  task automatic applyStimulus(input int sample, input bit checkStrobes);
    int waitCycles = 0;
    int nRst = 0, nEn = 0, nZap = 0, nRd = 0, nOverlap = 0;
    bit seen = 0;
    @(negedge clk_b);
    while (!bus.probka_ready && waitCycles < 50) begin
      @(negedge clk_b);
      waitCycles++;
    end
    if (!bus.probka_ready) checkOutput("readyTimeout", 0, 1);
    bus.probka_in    = DATA_W'(sample);
    bus.probka_valid = 1'b1;
    @(posedge clk_b);
    history.push_back(sample);
    #1 bus.probka_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk_b);
      nRst += int'(bus.FSM_reset_Acc);
      nEn  += int'(bus.FSM_Acc_en);
      nZap += int'(bus.FSM_Acc_zapis);
      nRd  += int'(bus.coef_rd_en);
      if ((int'(bus.FSM_reset_Acc) + int'(bus.FSM_Acc_en) + int'(bus.FSM_Acc_zapis)) > 1) nOverlap++;
      if (bus.FSM_Acc_en) lastSuma = int'(bus.suma_wynik);
      if (bus.wynik_valid) begin
        seen        = 1;
        lastLatency = cyc;
        lastResult  = int'(resultReg);
      end
    end
    if (!seen) begin
      checkOutput("validTimeout", 0, 1);
      lastResult = -1;
    end else begin
      checkOutput("latency", lastLatency, N_TAPS + 3);
    end
    checkOutput("goldenResult", lastResult, golden());
    if (checkStrobes) begin
      checkOutput("resetAccCount", nRst, 1);
      checkOutput("accEnCount", nEn, N_TAPS);
      checkOutput("zapisCount", nZap, 1);
      checkOutput("romReadCount", nRd, N_TAPS);
      checkOutput("strobeOverlap", nOverlap, 0);
    end
  endtask

  initial begin
    int accepted;
    int results;
    int data;
    int enSeen;
    int pulses;
    bus.probka_valid = 1'b0;
    bus.probka_in    = '0;
    setRom(0);
    repeat (3) @(posedge clk_b);
    @(negedge clk_b);
    rst_n = 1'b1;
    @(negedge clk_b);
    checkOutput("resetStrobes", int'({bus.FSM_reset_Acc, bus.FSM_Acc_en, bus.FSM_Acc_zapis,
                                      bus.wynik_valid, bus.coef_rd_en, bus.busy}), 0);
    checkOutput("resetReady", int'(bus.probka_ready), 1);
    checkOutput("resetSuma", int'(bus.suma_wynik), 0);
    checkOutput("resetAddr", int'(bus.coef_addr), 0);

    $display("[TB] impulse response");
    for (int i = 0; i < 17; i++) begin
      applyStimulus((i == 0) ? 1 : 0, i == 0);
      checkOutput($sformatf("impulse%0d", i), lastResult, (i < 16) ? i + 1 : 0);
    end

    $display("[TB] extreme signed");
    setRom(1);
    for (int i = 0; i < 16; i++) applyStimulus(-128, i == 15);
    checkOutput("extremeSuma", lastSuma, 262144);
    checkOutput("extremeResult", lastResult, 0);

    $display("[TB] mixed sign");
    setRom(2);
    applyStimulus(-3, 1'b0);
    checkOutput("mixedResult", lastResult, 'hFFF1);

    $display("[TB] backpressure");
    setRom(3);
    accepted = 0;
    results  = 0;
    data     = 1;
    bus.probka_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_b);
      bus.probka_in = DATA_W'(data);
      if (bus.probka_ready === bus.busy) checkOutput("readyVsBusy", int'(bus.probka_ready), int'(!bus.busy));
      if (bus.probka_ready) begin
        history.push_back(data);
        accepted++;
      end
      if (bus.wynik_valid) begin
        results++;
        checkOutput($sformatf("bpResult%0d", results), int'(resultReg), golden());
      end
      data++;
    end
    bus.probka_valid = 1'b0;
    checkOutput("bpAccepted", accepted, 3);
    checkOutput("bpResults", results, 3);

    $display("[TB] reset mid-MAC");
    setRom(4);
    applyStimulus(7, 1'b0);
    @(negedge clk_b);
    bus.probka_in    = DATA_W'(50);
    bus.probka_valid = 1'b1;
    @(posedge clk_b);
    #1 bus.probka_valid = 1'b0;
    enSeen = 0;
    for (int c = 0; c < 30 && enSeen < 8; c++) begin
      @(negedge clk_b);
      if (bus.FSM_Acc_en) enSeen++;
    end
    checkOutput("reachedTap7", enSeen, 8);
    rst_n = 1'b0;
    #1;
    checkOutput("abortStrobes", int'({bus.FSM_reset_Acc, bus.FSM_Acc_en, bus.FSM_Acc_zapis,
                                      bus.wynik_valid, bus.coef_rd_en, bus.busy}), 0);
    checkOutput("abortSuma", int'(bus.suma_wynik), 0);
    checkOutput("abortAddr", int'(bus.coef_addr), 0);
    repeat (2) @(negedge clk_b);
    rst_n = 1'b1;
    history.delete();
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_b);
      pulses += int'(bus.wynik_valid);
    end
    checkOutput("noPartialPulse", pulses, 0);
    setRom(5);
    applyStimulus(1, 1'b1);
    checkOutput("afterResetResult", lastResult, 2);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
